// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants, key-event record and assembler state type.
package ps2_pkg;

  localparam logic [7:0]  PS2_EXT       = 8'hE0;
  localparam logic [7:0]  PS2_BRK       = 8'hF0;
  localparam logic [7:0]  PS2_PAUSE     = 8'hE1;
  localparam int unsigned PS2_PAUSE_LEN = 8;

  // One assembled key event as stored in the event FIFO.
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_evt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } ps2_state_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Generic synchronous FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module ps2_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     computerClk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Qualify requests against occupancy.
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
  end

  // Storage, pointers and occupancy; storage resets so the head reads 0.
  always_ff @(posedge computerClk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event.sv
// Assembles set-2 scan-code prefix sequences into key events, queues them in
// an event FIFO and keeps sticky overflow / frame-error flags.
import ps2_pkg::*;

module ps2_key_event #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   computerClk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   in_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_code,
  output logic                   out_ext,
  output logic                   out_break,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   frame_err,
  input  logic                   clr_flags
);

  ps2_state_t state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       overflow_q, frame_err_q;
  logic       emit;
  ps2_evt_t   evt;
  ps2_evt_t   head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_code  = head.code;
  assign out_ext   = head.ext;
  assign out_break = head.brk;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

  // Prefix decode: next state, skip count and the event pushed this cycle.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    evt     = '{code: in_data, ext: 1'b0, brk: 1'b0};
    if (in_valid) begin
      if (in_err) begin
        state_d = ST_IDLE;
        skip_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (in_data == PS2_EXT)        state_d = ST_EXT;
            else if (in_data == PS2_BRK)   state_d = ST_BRK;
            else if (in_data == PS2_PAUSE) begin
              state_d = ST_PAUSE;
              skip_d  = 3'(PS2_PAUSE_LEN - 1);
            end else emit = 1'b1;
          end
          ST_EXT: begin
            if (in_data == PS2_BRK)      state_d = ST_EXT_BRK;
            else if (in_data != PS2_EXT) begin
              emit    = 1'b1;
              evt.ext = 1'b1;
              state_d = ST_IDLE;
            end
          end
          ST_BRK: begin
            emit    = 1'b1;
            evt.brk = 1'b1;
            state_d = ST_IDLE;
          end
          ST_EXT_BRK: begin
            emit    = 1'b1;
            evt.ext = 1'b1;
            evt.brk = 1'b1;
            state_d = ST_IDLE;
          end
          ST_PAUSE: begin
            // The byte seen at count 1 is the last of the sequence.
            if (skip_q <= 3'd1) begin
              emit     = 1'b1;
              evt.code = PS2_PAUSE;
              skip_d   = '0;
              state_d  = ST_IDLE;
            end else begin
              skip_d = skip_q - 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            skip_d  = '0;
          end
        endcase
      end
    end
  end

  // Assembler state and sticky flags; a set wins over clr_flags.
  always_ff @(posedge computerClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      if (emit && fifo_full && !pop) overflow_q <= 1'b1;
      else if (clr_flags)            overflow_q <= 1'b0;
      if (in_valid && in_err)        frame_err_q <= 1'b1;
      else if (clr_flags)            frame_err_q <= 1'b0;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(ps2_evt_t))
  ) u_fifo (
    .computerClk (computerClk),
    .rst_n       (rst_n),
    .push_i      (emit),
    .push_data_i (evt),
    .pop_i       (out_ready),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

endmodule

// File: tb/tb_ps2_key_event.sv
// Scoreboard bench for ps2_key_event: a byte-level reference model pushes
// expected events, a monitor compares the FIFO head and status every cycle.
module tb_ps2_key_event;

  localparam int DEPTH = 4;

  logic       computerClk = 1'b0;
  logic       rst_n       = 1'b0;
  logic       in_valid    = 1'b0;
  logic [7:0] in_data     = 8'h00;
  logic       in_err      = 1'b0;
  logic       out_ready   = 1'b0;
  logic       clr_flags   = 1'b0;
  logic       out_valid;
  logic [7:0] out_code;
  logic       out_ext;
  logic       out_break;
  logic [$clog2(DEPTH):0] level;
  logic       overflow;
  logic       frame_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state
  logic [9:0] exp_q[$];
  int         mlevel     = 0;
  bit         mov        = 0;
  bit         mfe        = 0;
  bit         ext_s      = 0;
  bit         brk_s      = 0;
  int         pause_left = 0;

  ps2_key_event #(.DEPTH(DEPTH)) dut (
    .computerClk (computerClk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_err      (in_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .out_ext     (out_ext),
    .out_break   (out_break),
    .level       (level),
    .overflow    (overflow),
    .frame_err   (frame_err),
    .clr_flags   (clr_flags)
  );

  always #5 computerClk = ~computerClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: applies the prefix rules to each accepted byte and
  // tracks the queue occupancy at every rising edge.
  initial begin
    logic [7:0] b;
    logic [9:0] ev;
    bit have, pop, set_fe, set_ov;
    forever begin
      @(posedge computerClk);
      if (!rst_n) begin
        exp_q.delete();
        mlevel = 0; mov = 0; mfe = 0;
        ext_s = 0; brk_s = 0; pause_left = 0;
      end else begin
        pop = (mlevel > 0) && out_ready;
        have = 0; set_fe = 0; set_ov = 0; ev = '0;
        b = in_data;
        if (in_valid) begin
          if (in_err) begin
            set_fe = 1; ext_s = 0; brk_s = 0; pause_left = 0;
          end else if (pause_left > 0) begin
            pause_left--;
            if (pause_left == 0) begin have = 1; ev = {8'hE1, 2'b00}; end
          end else if (brk_s) begin
            have = 1; ev = {b, ext_s, 1'b1}; ext_s = 0; brk_s = 0;
          end else if (b == 8'hE0) ext_s = 1;
          else if (b == 8'hF0) brk_s = 1;
          else if (b == 8'hE1 && !ext_s) pause_left = 7;
          else begin
            have = 1; ev = {b, ext_s, 1'b0}; ext_s = 0;
          end
        end
        if (have) begin
          if (mlevel == DEPTH && !pop) set_ov = 1;
          else begin exp_q.push_back(ev); mlevel++; end
        end
        if (pop) mlevel--;
        if (set_fe) mfe = 1; else if (clr_flags) mfe = 0;
        if (set_ov) mov = 1; else if (clr_flags) mov = 0;
      end
    end
  end

  // Monitor: compare status and head on the falling edge.
  initial begin
    forever begin
      @(negedge computerClk);
      if (!rst_n) begin
        check("rst_level", 32'(level), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_flags", {30'd0, overflow, frame_err}, 0);
        check("rst_head", {22'd0, out_code, out_ext, out_break}, 0);
      end else begin
        check("level", 32'(level), 32'(mlevel));
        check("out_valid", 32'(out_valid), 32'(mlevel != 0));
        check("overflow", 32'(overflow), 32'(mov));
        check("frame_err", 32'(frame_err), 32'(mfe));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL spurious_event: got %0h, expected none at %0t",
                     {out_code, out_ext, out_break}, $time);
          end else begin
            check("head", {22'd0, out_code, out_ext, out_break}, 32'(exp_q[0]));
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [7:0] d, input bit e, input bit rdy, input bit clr);
    @(posedge computerClk); #1;
    in_valid = v; in_data = d; in_err = e; out_ready = rdy; clr_flags = clr;
  endtask

  task automatic send(input logic [7:0] d, input bit rdy);
    cyc(1, d, 0, rdy, 0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, rdy, 0);
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    idle(2, 0);
    @(posedge computerClk); #1; rst_n = 1'b1;

    // Make and break of 1C
    send(8'h1C, 0); send(8'hF0, 0); send(8'h1C, 0);
    idle(1, 0);
    idle(DEPTH + 2, 1);

    // Extended make/break of 75, held
    send(8'hE0, 0); send(8'h75, 0);
    idle(1, 0);
    @(negedge computerClk); check("ext_level1", 32'(level), 1);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    idle(1, 0);
    @(negedge computerClk); check("ext_level2", 32'(level), 2);
    idle(DEPTH + 2, 1);

    // Pause sequence: one event after the eighth byte
    for (int i = 0; i < 8; i++) send(pause_seq[i], 0);
    idle(1, 0);
    @(negedge computerClk); check("pause_level", 32'(level), 1);
    idle(DEPTH + 2, 1);

    // Errored byte cancels a pending E0
    send(8'hE0, 0); cyc(1, 8'h55, 1, 0, 0); send(8'h1C, 0);
    idle(1, 0);
    @(negedge computerClk); check("ferr_set", 32'(frame_err), 1);
    cyc(0, 8'h00, 0, 0, 1);
    idle(DEPTH + 2, 1);
    @(negedge computerClk); check("ferr_clr", 32'(frame_err), 0);

    // Overflow, then a push accepted alongside a pop while full
    for (int i = 1; i <= 5; i++) send(8'(i), 0);
    idle(1, 0);
    @(negedge computerClk);
    check("ovf_level", 32'(level), DEPTH);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_head", 32'(out_code), 1);
    send(8'h06, 1);
    idle(1, 0);
    @(negedge computerClk); check("full_pushpop_level", 32'(level), DEPTH);
    idle(DEPTH + 2, 1);
    cyc(0, 8'h00, 0, 0, 1);

    // Reset mid-prefix with events queued
    send(8'h1C, 0); send(8'h2C, 0); send(8'hF0, 0);
    @(posedge computerClk); #1;
    in_valid = 0; rst_n = 1'b0;
    idle(2, 0);
    @(posedge computerClk); #1; rst_n = 1'b1;
    send(8'h1C, 0);
    idle(1, 0);
    @(negedge computerClk);
    check("post_rst_level", 32'(level), 1);
    check("post_rst_head", {22'd0, out_code, out_ext, out_break}, {22'd0, 8'h1C, 2'b00});
    idle(DEPTH + 2, 1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      int r;
      r = int'($urandom_range(0, 9));
      d = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : (r == 2) ? 8'hE1 : 8'($urandom_range(0, 255));
      cyc(bit'($urandom_range(0, 1)), d, ($urandom_range(0, 29) == 0),
          bit'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
    end

    // Bounded final drain
    for (int i = 0; i < 4 * DEPTH && mlevel != 0; i++) cyc(0, 8'h00, 0, 1, 0);
    idle(2, 0);
    check("final_queue_empty", 32'(exp_q.size()), 0);
    check("final_level", 32'(level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_event.md
# ps2_key_event

Downstream stage of the PS/2 frame receiver. It consumes the stream of validated scan-code bytes (set 2) and assembles prefix sequences (E0, F0, E0 F0, the 8-byte E1 Pause sequence) into single key events. Each event is one code byte plus extended and break flags. Events are buffered in a small FIFO and handed to the host logic over a ready/valid interface, with sticky error and overflow flags.

## Interface
Parameters:
- DEPTH, 4, event FIFO depth; power of two, 2..16.

Ports:
- computerClk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  one-cycle strobe: in_data holds a received byte.
- in_data  in  8  received scan-code byte.
- in_err  in  1  qualifies in_valid: the frame had a parity/stop error and in_data is garbage.
- out_valid  out  1  FIFO head holds an event.
- out_ready  in  1  consumer accepts the head when high together with out_valid.
- out_code  out  8  event code byte.
- out_ext  out  1  event was E0-prefixed.
- out_break  out  1  event is a release (F0-prefixed).
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- frame_err  out  1  sticky: an in_err byte was received.
- clr_flags  in  1  synchronous clear of overflow and frame_err.

## Operation
- Assembler FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (E1 seen, swallowing bytes).
- The FSM acts only on cycles where in_valid=1.
- IDLE:
  - E0 goes to EXT; F0 goes to BRK.
  - E1 goes to PAUSE and loads the skip counter with 7.
  - Any other byte emits {code, ext=0, brk=0} and stays in IDLE.
- EXT:
  - F0 goes to EXT_BRK.
  - E0 stays in EXT.
  - Any other byte emits {code, ext=1, brk=0} and goes to IDLE.
- BRK: any byte emits {code, 0, 1} and goes to IDLE. An F0 here is emitted as code F0 (no prefix nesting).
- EXT_BRK: any byte emits {code, 1, 1} and goes to IDLE.
- PAUSE:
  - The 3-bit counter decrements on each byte.
  - When the byte that brings the count to 0 arrives, the block emits {E1, 0, 0} and goes to IDLE.
  - Exactly one event is produced per 8-byte sequence.
- in_valid with in_err=1, in any state:
  - No event is emitted.
  - The FSM returns to IDLE and the skip counter clears.
  - frame_err is set.
- Emit means a push to the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the event is dropped and overflow is set.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted and level is unchanged.
- Pop happens when out_valid && out_ready.
- out_code, out_ext and out_break show the FIFO head. They hold steady while out_valid=1 and no pop occurs.
- Pointers are log2(DEPTH) bits and wrap naturally. level counts 0..DEPTH.
- clr_flags has lower priority than a set in the same cycle: the flag stays 1.

## Timing
- Reset values:
  - FSM = IDLE, skip counter = 0, pointers = 0.
  - level = 0, out_valid = 0.
  - out_code = 0, out_ext = 0, out_break = 0 (storage reset to 0).
  - overflow = 0, frame_err = 0.
- Latency: the final byte's in_valid in cycle k is pushed at the edge ending cycle k. out_valid=1 and level incremented from cycle k+1.
- Back-to-back in_valid on consecutive cycles is supported; one byte per cycle.
- A pop in cycle k updates level and the head from cycle k+1.
- out_valid is combinational from the registered level (level != 0). There is no combinational path from in_valid or out_ready to outputs.
- Reset asserted mid-sequence (e.g. after E0) discards the partial prefix and all FIFO contents.

## Structure
- Shared package ps2_pkg holds:
  - Constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_PAUSE_LEN=8.
  - The event struct {code[7:0], ext, brk}.
  - The assembler state enum.
- Sub-module ps2_evt_fifo: generic synchronous FIFO of 10-bit entries with DEPTH parameter, push/pop/full/empty/level. The top keeps the FSM and the flags.

## Test plan
- Bytes 1C; F0 1C → two events {1C,0,0}, {1C,0,1}. out_valid is high the cycle after each final byte.
- E0 75; E0 F0 75 → {75,1,0}, {75,1,1}. level goes 1 then 2 with out_ready=0.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → exactly one event {E1,0,0}, emitted after the 8th byte.
- E0 then an in_err byte, then 1C → frame_err=1, one event {1C,0,0} (ext=0). clr_flags clears frame_err.
- With out_ready=0 and DEPTH=4, send 5 make codes 01..05:
  - level=4, overflow=1, head=01.
  - Draining yields 01..04.
  - A 5th push made in the same cycle as a pop is accepted, with level staying at 4.
- Assert rst_n low after F0 with 2 events queued → level=0, out_valid=0. Next byte 1C yields {1C,0,0}.
